// File: rtl/serial_pattern_gen.sv
// Serial bit-stream transmitter: loads a WIDTH-bit word and shifts it out MSB-first on x.
// Define SERIAL_GEN_PARITY_EN to append one even-parity bit to every frame.
module serial_pattern_gen #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             x,
    output logic             frame,
    output logic             done,
    output logic [7:0]       frame_cnt
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SERIAL_GEN_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             x_n, frame_n, done_n, ready_n;
    logic [7:0]       frame_cnt_n;

    // Outputs are computed one cycle ahead so every output leaves a flop.
    // The shift register rotates rather than shifts so its parity stays that of the loaded word.
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        cnt_n       = cnt;
        x_n         = IDLE_BIT;
        frame_n     = 1'b0;
        done_n      = 1'b0;
        ready_n     = 1'b0;
        frame_cnt_n = frame_cnt;
        case (state)
            IDLE: begin
                ready_n = 1'b1;
                if (load && ready) begin
                    state_n = SHIFT;
                    shreg_n = data_in;
                    cnt_n   = '0;
                    x_n     = data_in[WIDTH-1];
                    frame_n = 1'b1;
                    ready_n = 1'b0;
                end
            end
            SHIFT: begin
                shreg_n = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
                if (cnt == LAST_BIT) begin
`ifdef SERIAL_GEN_PARITY_EN
                    state_n = PAR;
                    x_n     = ^shreg;
                    frame_n = 1'b1;
`else
                    state_n     = IDLE;
                    done_n      = 1'b1;
                    ready_n     = 1'b1;
                    frame_cnt_n = frame_cnt + 8'd1;
`endif
                end else begin
                    cnt_n   = cnt + 1'b1;
                    x_n     = shreg[WIDTH-2];
                    frame_n = 1'b1;
                end
            end
`ifdef SERIAL_GEN_PARITY_EN
            PAR: begin
                state_n     = IDLE;
                done_n      = 1'b1;
                ready_n     = 1'b1;
                frame_cnt_n = frame_cnt + 8'd1;
            end
`endif
            default: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            x         <= IDLE_BIT;
            frame     <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b1;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            cnt       <= cnt_n;
            x         <= x_n;
            frame     <= frame_n;
            done      <= done_n;
            ready     <= ready_n;
            frame_cnt <= frame_cnt_n;
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen: table of frames plus reset, busy-load and wrap sequences.
module tb_serial_pattern_gen;

    localparam int W = 8;
`ifdef SERIAL_GEN_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_LEN = W + (PAR_EN ? 1 : 0);
    localparam int NVEC = 10;

    logic         mclk;
    logic         rst;
    logic [W-1:0] data_in;
    logic         load;
    logic         ready;
    logic         x;
    logic         frame;
    logic         done;
    logic [7:0]   frame_cnt;

    serial_pattern_gen #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
        .mclk      (mclk),
        .rst       (rst),
        .data_in   (data_in),
        .load      (load),
        .ready     (ready),
        .x         (x),
        .frame     (frame),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    typedef struct {
        logic [W-1:0] data;
        logic         par;
    } vec_t;

    vec_t       vecs [NVEC];
    logic       exp_q [$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt = 8'd0;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a falling edge; leaves the bench in cycle 1 of the new frame.
    task automatic applyStimulus(input logic [W-1:0] d, input logic p);
        load    = 1'b1;
        data_in = d;
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
        if (PAR_EN) exp_q.push_back(p);
        @(negedge mclk);
        load    = 1'b0;
        data_in = W'($urandom);
    endtask

    task automatic collectBits(input int n, input bit inject);
        logic e;
        for (int k = 0; k < n; k++) begin
            if (exp_q.size() == 0) begin
                checkOutput("queue_underflow", 8'd1, 8'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("x_bit", x, e);
            end
            checkOutput("frame_hi", frame, 1'b1);
            checkOutput("ready_lo", ready, 1'b0);
            checkOutput("done_lo", done, 1'b0);
            if (inject && k == 3) begin
                load    = 1'b1;
                data_in = '0;
            end else if (inject && k == 4) begin
                load = 1'b0;
            end
            @(negedge mclk);
        end
    endtask

    task automatic checkDone();
        exp_cnt = exp_cnt + 8'd1;
        checkOutput("done_pulse", done, 1'b1);
        checkOutput("ready_back", ready, 1'b1);
        checkOutput("frame_end", frame, 1'b0);
        checkOutput("x_idle", x, 1'b0);
        checkOutput("frame_cnt", frame_cnt, exp_cnt);
    endtask

    task automatic runFrame(input logic [W-1:0] d, input logic p, input bit inject);
        applyStimulus(d, p);
        collectBits(FRAME_LEN, inject);
        checkDone();
    endtask

    initial begin
        vecs[0] = '{8'hFB, 1'b1};
        vecs[1] = '{8'h03, 1'b0};
        vecs[2] = '{8'hA5, 1'b0};
        vecs[3] = '{8'h5A, 1'b0};
        vecs[4] = '{8'hFF, 1'b0};
        vecs[5] = '{8'h00, 1'b0};
        vecs[6] = '{8'h80, 1'b1};
        vecs[7] = '{8'h01, 1'b1};
        vecs[8] = '{8'h7E, 1'b0};
        vecs[9] = '{8'h13, 1'b1};

        rst     = 1'b1;
        load    = 1'b1;
        data_in = '1;
        repeat (3) @(negedge mclk);
        checkOutput("rst_x", x, 1'b0);
        checkOutput("rst_frame", frame, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_ready", ready, 1'b1);
        checkOutput("rst_cnt", frame_cnt, 8'd0);
        rst  = 1'b0;
        load = 1'b0;
        @(negedge mclk);
        checkOutput("load_with_rst_frame", frame, 1'b0);
        checkOutput("load_with_rst_ready", ready, 1'b1);

        // Frames run back-to-back: each new load is raised during the previous done cycle.
        for (int i = 0; i < NVEC; i++) runFrame(vecs[i].data, vecs[i].par, 1'b0);

        runFrame(8'hFF, 1'b0, 1'b1);
        @(negedge mclk);
        checkOutput("busy_single_done", done, 1'b0);
        checkOutput("busy_no_restart", frame, 1'b0);

        applyStimulus(8'hC3, 1'b0);
        collectBits(4, 1'b0);
        rst = 1'b1;
        @(negedge mclk);
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = 8'd0;
        checkOutput("midrst_x", x, 1'b0);
        checkOutput("midrst_frame", frame, 1'b0);
        checkOutput("midrst_ready", ready, 1'b1);
        checkOutput("midrst_cnt", frame_cnt, 8'd0);
        checkOutput("midrst_done", done, 1'b0);
        for (int k = 0; k < 2 * FRAME_LEN; k++) begin
            @(negedge mclk);
            checkOutput("midrst_no_done", done, 1'b0);
            checkOutput("midrst_idle", frame, 1'b0);
        end

        for (int f = 0; f < 257; f++) begin
            runFrame(vecs[f % NVEC].data, vecs[f % NVEC].par, 1'b0);
            if (f == 255) checkOutput("wrap256", frame_cnt, 8'd0);
            if (f == 256) checkOutput("wrap257", frame_cnt, 8'd1);
        end

        @(negedge mclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
